// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
`timescale 1ns/1ps
package ps2_pkg;

  // Frame receiver states: waiting for a start bit, collecting the eight
  // data bits, then the parity bit, then the stop bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Prefix bytes that are folded into flags instead of being reported.
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Scancodes the keyboard command decoder cares about (set 2).
  // The arrow keys arrive with the E0 prefix.
  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_W     = 8'h1D;
  localparam logic [7:0] PS2_KEY_A     = 8'h1C;
  localparam logic [7:0] PS2_KEY_S     = 8'h1B;
  localparam logic [7:0] PS2_KEY_D     = 8'h23;
  localparam logic [7:0] PS2_KEY_SPACE = 8'h29;

  // PS/2 uses odd parity: the eight data bits plus the parity bit must
  // contain an odd number of ones.
  function automatic logic frame_parity_ok(input logic [7:0] data_byte,
                                           input logic       parity_bit);
    return (^data_byte) ^ parity_bit;
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Input conditioning for the PS/2 pins: synchronisers on both pins, a
// persistence filter on the clock line and a one-cycle falling-edge strobe.
// SYNC_STAGES must be at least 2.
`timescale 1ns/1ps
module ps2_input_filter #(
  parameter int FILTER_LEN  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ps2_clock,
  input  logic ps2_data,
  output logic fe,
  output logic data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   clk_level;
  logic [CW-1:0]          diff_cnt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = dat_sync[SYNC_STAGES-1];

  // Bring both asynchronous pins into the clock domain; idle bus level is 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Flip the filtered clock only after FILTER_LEN consecutive disagreeing
  // samples, and strobe fe in the cycle after a 1->0 flip is committed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_level <= 1'b1;
      diff_cnt  <= '0;
      fe        <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s != clk_level) begin
        if (diff_cnt == CW'(FILTER_LEN - 1)) begin
          clk_level <= clk_s;
          diff_cnt  <= '0;
          fe        <= clk_level;
        end else begin
          diff_cnt <= diff_cnt + 1'b1;
        end
      end else begin
        diff_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: deserialises 11-bit frames, checks
// start/parity/stop, folds E0/F0 prefixes into flags and reports one tagged
// scancode per key event.
`timescale 1ns/1ps
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_break,
  output logic       code_extended,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic fe;
  logic data_s;

  ps2_state_t state, state_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] timer, timer_next;
  logic          ext_pending, ext_next;
  logic          brk_pending, brk_next;
  logic [7:0]    code_next;
  logic          break_next, extended_next;
  logic          valid_next, error_next;

  ps2_input_filter #(
    .FILTER_LEN  (FILTER_LEN),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_filter (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .fe        (fe),
    .data_s    (data_s)
  );

  assign busy = (state != IDLE);

  // Register all frame state and the registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      timer         <= '0;
      ext_pending   <= 1'b0;
      brk_pending   <= 1'b0;
      code          <= '0;
      code_break    <= 1'b0;
      code_extended <= 1'b0;
      code_valid    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_next;
      bit_cnt       <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      timer         <= timer_next;
      ext_pending   <= ext_next;
      brk_pending   <= brk_next;
      code          <= code_next;
      code_break    <= break_next;
      code_extended <= extended_next;
      code_valid    <= valid_next;
      frame_error   <= error_next;
    end
  end

  // Next-state logic: the frame walk advances only on fe; the inactivity
  // timer aborts a partial frame, and an fe always restarts the timer first.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    timer_next    = timer;
    ext_next      = ext_pending;
    brk_next      = brk_pending;
    code_next     = code;
    break_next    = code_break;
    extended_next = code_extended;
    valid_next    = 1'b0;
    error_next    = 1'b0;

    if (state == IDLE || fe) begin
      timer_next = '0;
    end else if (timer == TIMER_LAST) begin
      timer_next = '0;
      state_next = IDLE;
      error_next = 1'b1;
      ext_next   = 1'b0;
      brk_next   = 1'b0;
    end else begin
      timer_next = timer + 1'b1;
    end

    if (fe) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = data_s;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_s && frame_parity_ok(shift_reg, parity_reg)) begin
            if (shift_reg == PS2_PREFIX_EXT) begin
              ext_next = 1'b1;
            end else if (shift_reg == PS2_PREFIX_BRK) begin
              brk_next = 1'b1;
            end else begin
              code_next     = shift_reg;
              break_next    = brk_pending;
              extended_next = ext_pending;
              valid_next    = 1'b1;
              ext_next      = 1'b0;
              brk_next      = 1'b0;
            end
          end else begin
            error_next = 1'b1;
            ext_next   = 1'b0;
            brk_next   = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
